// File: rtl/linproj_out_writer_if.sv
// Tile stream from the multi-matmul array into the linear-projection output writer.
interface linproj_out_writer_if #(
    parameter int unsigned TILE_W = 512
);
    logic              s_valid;
    logic              s_ready;
    logic [TILE_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/linproj_out_writer.sv
// Serializes C tiles from the matmul array into the output BRAM, one slice per cycle, row-major.
// Optional feature: define LINPROJ_OUT_SKID_EN for a one-tile pending register (back-to-back tiles).
module linproj_out_writer #(
    parameter int unsigned WIDTH_OUT      = 16,
    parameter int unsigned CHUNK_SIZE     = 4,
    parameter int unsigned NUM_CORES_A    = 2,
    parameter int unsigned NUM_CORES_B    = 1,
    parameter int unsigned TOTAL_MODULES  = 4,
    parameter int unsigned ROW_SIZE_MAT_C = 2,
    parameter int unsigned COL_SIZE_MAT_C = 2,
    localparam int unsigned SLICE_W  = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B,
    localparam int unsigned TILE_W   = SLICE_W*TOTAL_MODULES,
    localparam int unsigned MAX_FLAG = ROW_SIZE_MAT_C*COL_SIZE_MAT_C,
    localparam int unsigned ADDR_W   = (MAX_FLAG*TOTAL_MODULES > 1) ? $clog2(MAX_FLAG*TOTAL_MODULES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    linproj_out_writer_if.slave        tile,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [SLICE_W-1:0]         wr_data,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned TIDX_W = (MAX_FLAG > 1) ? $clog2(MAX_FLAG) : 1;
    localparam int unsigned SIDX_W = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t              state;
    logic                s_ready_q;
    logic [TILE_W-1:0]   tile_reg;
    logic [TIDX_W-1:0]   tile_idx;
    logic [SIDX_W-1:0]   slice_idx;

    logic                xfer_c;
    logic                emit_c;
    logic [SIDX_W-1:0]   emit_slice_c;
    logic [TILE_W-1:0]   emit_src_c;
    logic                tile_end_c;
    logic                last_tile_c;

`ifdef LINPROJ_OUT_SKID_EN
    localparam int unsigned ACC_W = $clog2(MAX_FLAG+1);

    logic [TILE_W-1:0]   pend_reg;
    logic                pend_full;
    logic [ACC_W-1:0]    acc_cnt;
    logic                more_c;

    // Room for another tile once this cycle's transfer (if any) is counted.
    assign more_c = (acc_cnt + ACC_W'(xfer_c)) < ACC_W'(MAX_FLAG);
`endif

    assign tile.s_ready = s_ready_q;
    assign xfer_c       = tile.s_valid && s_ready_q;
    assign last_tile_c  = (tile_idx == TIDX_W'(MAX_FLAG-1));

    // Slice 0 goes out straight from the bus on the accepting edge; the rest come from tile_reg.
    always_comb begin
        emit_c       = 1'b0;
        emit_slice_c = '0;
        emit_src_c   = tile_reg;
        if (state == ACCEPT && xfer_c) begin
            emit_c     = 1'b1;
            emit_src_c = tile.s_data;
        end else if (state == WRITE) begin
            emit_c       = 1'b1;
            emit_slice_c = slice_idx;
        end
    end

    assign tile_end_c = emit_c && (emit_slice_c == SIDX_W'(TOTAL_MODULES-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready_q <= 1'b0;
            tile_reg  <= '0;
            tile_idx  <= '0;
            slice_idx <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LINPROJ_OUT_SKID_EN
            pend_reg  <= '0;
            pend_full <= 1'b0;
            acc_cnt   <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (emit_c) begin
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(tile_idx) * ADDR_W'(TOTAL_MODULES) + ADDR_W'(emit_slice_c);
                wr_data <= emit_src_c[32'(emit_slice_c)*SLICE_W +: SLICE_W];
            end
`ifdef LINPROJ_OUT_SKID_EN
            if (xfer_c) acc_cnt <= acc_cnt + ACC_W'(1);
`endif

            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    s_ready_q <= 1'b0;
                    if (start) begin
                        state     <= ACCEPT;
                        tile_idx  <= '0;
                        slice_idx <= '0;
                        s_ready_q <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef LINPROJ_OUT_SKID_EN
                        pend_full <= 1'b0;
                        acc_cnt   <= '0;
`endif
                    end
                end
                ACCEPT: begin
                    s_ready_q <= 1'b1;
                    if (xfer_c) begin
                        tile_reg  <= tile.s_data;
                        slice_idx <= SIDX_W'(1);
                        state     <= WRITE;
`ifdef LINPROJ_OUT_SKID_EN
                        s_ready_q <= more_c;
`else
                        s_ready_q <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    slice_idx <= slice_idx + SIDX_W'(1);
`ifdef LINPROJ_OUT_SKID_EN
                    if (xfer_c) begin
                        pend_reg  <= tile.s_data;
                        pend_full <= 1'b1;
                        s_ready_q <= 1'b0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase

            // Tile boundary: finish the pass, chain the next tile, or go back for one.
            if (tile_end_c) begin
                slice_idx <= '0;
                if (last_tile_c) begin
                    state     <= DONE;
                    s_ready_q <= 1'b0;
                end else begin
                    tile_idx <= tile_idx + TIDX_W'(1);
`ifdef LINPROJ_OUT_SKID_EN
                    pend_full <= 1'b0;
                    s_ready_q <= more_c;
                    if (pend_full) begin
                        tile_reg <= pend_reg;
                        state    <= WRITE;
                    end else if (xfer_c && state == WRITE) begin
                        tile_reg <= tile.s_data;
                        state    <= WRITE;
                    end else begin
                        state <= ACCEPT;
                    end
`else
                    state     <= ACCEPT;
                    s_ready_q <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_linproj_out_writer.sv
// Directed bench for linproj_out_writer: table of expected BRAM writes plus hand-written corner sequences.
module tb_linproj_out_writer;

    localparam int unsigned WIDTH_OUT = 16;
    localparam int unsigned SLICE_W   = 128;
    localparam int unsigned TILE_W    = 512;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned EPS       = 8;
    localparam int          NWR       = 16;
`ifdef LINPROJ_OUT_SKID_EN
    localparam int          PERIOD    = 4;
`else
    localparam int          PERIOD    = 5;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SLICE_W-1:0]  wr_data;
    logic                busy;
    logic                done;

    linproj_out_writer_if #(.TILE_W(TILE_W)) tile_if ();

    linproj_out_writer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tile    (tile_if),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        logic [ADDR_W-1:0]  addr;
        logic [SLICE_W-1:0] data;
    } wr_rec_t;

    typedef struct {
        int tile;
        int slice;
        int addr;
        int off;
    } vec_t;

    wr_rec_t wlog[$];
    logic    sr_hist [0:1023];
    vec_t    vt [NWR];

    always @(negedge clk) begin
        if (wr_en) wlog.push_back('{cyc, wr_addr, wr_data});
        if (cyc < 1024) sr_hist[cyc] = tile_if.s_ready;
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [WIDTH_OUT-1:0] elem(input int t, input int k, input int e);
        return 16'(t*4096 + k*256 + e*16 + 9);
    endfunction

    function automatic logic [SLICE_W-1:0] exp_slice(input int t, input int k);
        logic [SLICE_W-1:0] s;
        for (int e = 0; e < EPS; e++) s[e*16 +: 16] = elem(t, k, e);
        return s;
    endfunction

    function automatic logic [TILE_W-1:0] make_tile(input int t);
        logic [TILE_W-1:0] x;
        for (int j = 0; j < 32; j++) x[j*16 +: 16] = elem(t, j/EPS, j%EPS);
        return x;
    endfunction

    task automatic chk(input string name, input logic [SLICE_W-1:0] act, input logic [SLICE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int scyc);
        start = 1'b1;
        scyc  = cyc;
        tick();
        start = 1'b0;
    endtask

    // Offer tile t and return the cycle in which the handshake was seen.
    task automatic send_tile(input int t, output int hcyc);
        tile_if.s_valid = 1'b1;
        tile_if.s_data  = make_tile(t);
        hcyc = -1;
        for (int i = 0; i < 60; i++) begin
            if (tile_if.s_ready) begin
                hcyc = cyc;
                tick();
                break;
            end
            tick();
        end
        if (hcyc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake tile %0d: got no s_ready expected s_ready within 60 cycles", t);
        end
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
        end
        if (dcyc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: got done=0 expected done=1 within 100 cycles");
        end
    endtask

    task automatic check_pass(input int base, input int h0, input bit chk_cyc, input string tag);
        wr_rec_t r;
        if (wlog.size() < base + NWR) begin
            n_vec++;
            n_err++;
            $display("FAIL %s write count: got %0d expected %0d", tag, wlog.size() - base, NWR);
        end else begin
            for (int i = 0; i < NWR; i++) begin
                r = wlog[base + i];
                chk($sformatf("%s addr[%0d]", tag, i), SLICE_W'(r.addr), SLICE_W'(vt[i].addr));
                chk($sformatf("%s data[%0d]", tag, i), r.data, exp_slice(vt[i].tile, vt[i].slice));
                if (chk_cyc) chk($sformatf("%s cycle[%0d]", tag, i), SLICE_W'(r.cyc), SLICE_W'(h0 + vt[i].off));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, base, cnt, found;
        int h [4];
        wr_rec_t r;

        tile_if.s_valid = 1'b0;
        tile_if.s_data  = '0;
        // Write i belongs to tile i/4, slice i%4, lands at address i.
        for (int i = 0; i < NWR; i++) vt[i] = '{i/4, i%4, i, 1 + PERIOD*(i/4) + (i%4)};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset s_ready", SLICE_W'(tile_if.s_ready), '0);
        chk("reset wr_en",   SLICE_W'(wr_en), '0);
        chk("reset wr_addr", SLICE_W'(wr_addr), '0);
        chk("reset wr_data", wr_data, '0);
        chk("reset busy",    SLICE_W'(busy), '0);
        chk("reset done",    SLICE_W'(done), '0);
        rst_n = 1'b1;
        tick();

        // s_valid in IDLE is not consumed
        base = wlog.size();
        tile_if.s_valid = 1'b1;
        tile_if.s_data  = make_tile(7);
        repeat (3) begin
            chk("idle s_ready", SLICE_W'(tile_if.s_ready), '0);
            tick();
        end
        chk("idle writes", SLICE_W'(wlog.size() - base), '0);
        chk("idle busy", SLICE_W'(busy), '0);
        tile_if.s_valid = 1'b0;
        tick();

        // Basic pass, source always valid
        base = wlog.size();
        pulse_start(s);
        chk("basic busy after start", SLICE_W'(busy), SLICE_W'(1));
        for (int t = 0; t < 4; t++) send_tile(t, h[t]);
        tile_if.s_valid = 1'b0;
        wait_done(d);
        chk("basic first handshake", SLICE_W'(h[0]), SLICE_W'(s + 1));
        check_pass(base, h[0], 1'b1, "basic");
        chk("basic done cycle", SLICE_W'(d), SLICE_W'(h[0] + 1 + PERIOD*3 + 3 + 1));
        chk("basic busy at done", SLICE_W'(busy), '0);
`ifdef LINPROJ_OUT_SKID_EN
        chk("skid second handshake", SLICE_W'(h[1]), SLICE_W'(h[0] + 1));
        for (int c = 1; c <= 3; c++)
            chk($sformatf("skid s_ready after last accept +%0d", c), SLICE_W'(sr_hist[h[3] + c]), '0);
`else
        chk("basic second handshake", SLICE_W'(h[1]), SLICE_W'(h[0] + 5));
        for (int c = 1; c <= 4; c++)
            chk($sformatf("latency s_ready h0+%0d", c), SLICE_W'(sr_hist[h[0] + c]), '0);
        chk("latency s_ready h0+5", SLICE_W'(sr_hist[h[0] + 5]), SLICE_W'(1));
`endif

        // done holds; s_valid in DONE is not consumed
        base = wlog.size();
        tile_if.s_valid = 1'b1;
        tile_if.s_data  = make_tile(9);
        repeat (3) begin
            chk("done hold", SLICE_W'(done), SLICE_W'(1));
            chk("done s_ready", SLICE_W'(tile_if.s_ready), '0);
            tick();
        end
        chk("done writes", SLICE_W'(wlog.size() - base), '0);
        tile_if.s_valid = 1'b0;

        // Second pass: source stall between tiles 1 and 2, stray start during WRITE
        base = wlog.size();
        pulse_start(s);
        chk("restart done cleared", SLICE_W'(done), '0);
        chk("restart busy", SLICE_W'(busy), SLICE_W'(1));
        send_tile(0, h[0]);
        send_tile(1, h[1]);
        tile_if.s_valid = 1'b0;
        repeat (5) tick();
        send_tile(2, h[2]);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_tile(3, h[3]);
        tile_if.s_valid = 1'b0;
        wait_done(d);
        check_pass(base, h[0], 1'b0, "stall");
        chk("stall total writes", SLICE_W'(wlog.size() - base), SLICE_W'(NWR));
`ifndef LINPROJ_OUT_SKID_EN
        cnt = 0;
        for (int i = base; i < wlog.size(); i++) begin
            r = wlog[i];
            if (r.cyc >= h[1] + 5 && r.cyc <= h[2]) cnt++;
        end
        chk("stall gap writes", SLICE_W'(cnt), '0);
        if (wlog.size() >= base + NWR) begin
            r = wlog[base + 8];
            chk("stall tile2 first write cycle", SLICE_W'(r.cyc), SLICE_W'(h[2] + 1));
        end
`endif

        // Reset mid-pass during slice 2 of tile 1
        pulse_start(s);
        send_tile(0, h[0]);
        send_tile(1, h[1]);
        tile_if.s_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_en && wr_addr == ADDR_W'(6)) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("midpass reached addr 6", SLICE_W'(found), SLICE_W'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset s_ready", SLICE_W'(tile_if.s_ready), '0);
        chk("midreset wr_en",   SLICE_W'(wr_en), '0);
        chk("midreset wr_addr", SLICE_W'(wr_addr), '0);
        chk("midreset wr_data", wr_data, '0);
        chk("midreset busy",    SLICE_W'(busy), '0);
        chk("midreset done",    SLICE_W'(done), '0);
        #2;
        rst_n = 1'b1;
        tick();
        base = wlog.size();
        pulse_start(s);
        send_tile(5, h[0]);
        tile_if.s_valid = 1'b0;
        tick();
        if (wlog.size() > base) begin
            r = wlog[base];
            chk("after reset first addr", SLICE_W'(r.addr), '0);
            chk("after reset first data", r.data, exp_slice(5, 0));
            chk("after reset first cycle", SLICE_W'(r.cyc), SLICE_W'(h[0] + 1));
        end else begin
            chk("after reset write seen", SLICE_W'(wlog.size() - base), SLICE_W'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
